// File: rtl/cpu_pkg.sv
// Shared types and constants for the datapath's load/store path.
package cpu_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned REQ_ADDR_W = 16;
    localparam int unsigned OPCODE_W   = 4;

    localparam logic [OPCODE_W-1:0] OP_LW = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_SW = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // True for the two opcodes that the data memory services.
    function automatic logic is_mem_opcode(input logic [OPCODE_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // Byte address is bad if odd or if it reaches past a 2**aw word memory.
    function automatic logic is_bad_addr(input logic [REQ_ADDR_W-1:0] addr,
                                         input int unsigned aw);
        return addr[0] || ((addr >> (aw + 1)) != '0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, combinational read, no reset.
module dmem_array #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port.
    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready data-memory responder with programmable wait states and
// alignment/range error reporting.
module data_mem_responder
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [REQ_ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err
);

    // BUSY lasts WAIT_STATES+1 cycles: one to register the request, then
    // WAIT_STATES wait cycles, giving resp_valid after edge N+1+WAIT_STATES.
    localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              mem_we_c;
    logic [DATA_W-1:0] mem_rdata;

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dmem_array (
        .clock (clock),
        .we    (mem_we_c && !reset),
        .waddr (idx_q),
        .wdata (wdata_q),
        .raddr (idx_q),
        .rdata (mem_rdata)
    );

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Next-state, request capture, commit and response logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_we_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    wr_d        = req_write;
                    idx_d       = req_addr[ADDR_W:1];
                    wdata_d     = req_wdata;
                    err_d       = is_bad_addr(req_addr, ADDR_W);
                    cnt_d       = CNT_W'(WAIT_STATES);
                    req_ready_d = 1'b0;
                    state_d     = BUSY;
                end
            end

            BUSY: begin
                if (cnt_q == '0) begin
                    // Commit: write memory or capture read data.
                    if (err_q) begin
                        resp_rdata_d = '0;
                    end else if (wr_q) begin
                        mem_we_c     = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        resp_rdata_d = mem_rdata;
                    end
                    resp_err_d   = err_q;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end

            default: begin
                resp_valid_d = 1'b0;
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
                req_ready_d  = 1'b1;
                state_d      = IDLE;
            end
        endcase
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
